ftdi_fifo_responder: RTL
========================

Name: ftdi_fifo_responder

Overview:
Synthesizable model of the device (FT232H-style) end of the async 245 FIFO bus. The FPGA-side FTDI interface drives this bus as host. The responder answers its RD#/WR# strobes, drives RXF#/TXE#, and buffers bytes in both directions. It serves as an on-chip loopback target and a bench responder for the FTDI interface. The PC side is replaced by a simple push/pop port.

Parameters:
DEPTH, 16, entries in each internal buffer (power of 2, ≥2)
RECOVERY, 2, cycles RXF#/TXE# stay high after a strobe's rising edge (≥1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ftdi_rd_n  in  1  RD# from host interface, same clock domain
ftdi_wr_n  in  1  WR# from host interface, same clock domain
adbus_in  in  8  byte driven by host during writes
adbus_out  out  8  byte driven to host during reads
adbus_oe  out  1  responder drives adbus
rxf_n  out  1  low = read data available
txe_n  out  1  low = write space available
pc_data  in  8  byte to queue toward host (rx buffer)
pc_push  in  1  enqueue pc_data
pc_full  out  1  rx buffer full
pc_pop  in  1  dequeue from tx buffer
pc_q  out  8  tx buffer head
pc_empty  out  1  tx buffer empty
rx_count  out  $clog2(DEPTH)+1  rx buffer occupancy
tx_count  out  $clog2(DEPTH)+1  tx buffer occupancy
err_clear  in  1  clears protocol_err
protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Reset (async, reset_n=0): both buffers empty; counts 0; rxf_n=1; txe_n=1; adbus_oe=0; adbus_out=0; pc_empty=1; pc_full=0; protocol_err=0; FSM=IDLE; rd_q/wr_q history regs=1.
- Edge detect: rd_q/wr_q hold last-cycle RD#/WR#. Fall = q=1 & now=0. Rise = q=0 & now=1.
- FSM states: IDLE, READING, WRITING, RECOVER.
  - IDLE: rxf_n = rx_empty, txe_n = tx_full (registered, 1-cycle lag). RD# fall and rx non-empty -> READING. Else WR# fall and tx not full -> WRITING; adbus_in pushed into tx buffer on that same edge.
  - READING: rxf_n=1, txe_n=1. On RD# rise: pop rx head -> RECOVER.
  - WRITING: rxf_n=1, txe_n=1. On WR# rise -> RECOVER.
  - RECOVER: rxf_n=1, txe_n=1 for RECOVERY cycles (counter), then -> IDLE.
- adbus_out = rx buffer head, combinational from buffer RAM/regs. This makes data valid in the same cycle RD# goes low, because the host captures on its first RD#-low cycle.
- adbus_oe = ~ftdi_rd_n & (state==IDLE|READING) & ~rx_empty, combinational.
- pc_q = tx head, combinational. pc_pop while empty: ignored. pc_push while full: ignored, data dropped.
- Simultaneous pc_push with READING pop: both occur; rx_count unchanged. Simultaneous pc_pop with write push: both occur.
- Counts: wrap-free pointers of width $clog2(DEPTH); count saturates at DEPTH, never wraps.
- protocol_err is set, at the cycle detected, by any of:
  - RD# and WR# both low in the same cycle;
  - RD# fall while rx empty;
  - WR# fall while tx full;
  - any strobe fall in READING/WRITING/RECOVER.
  The offending strobe causes no buffer push or pop. err_clear clears the flag; a set condition in the same cycle wins.
- A strobe held low indefinitely keeps the FSM in READING/WRITING; no timeout.

Test Plan:
- Reset values: assert reset_n=0 mid-READING with rx_count=3 -> all outputs at reset values immediately; after release rx_count=0, rxf_n=1; rxf_n remains 1 (rx empty).
- Single read: pc_push 0xA5, drive RD# low 3 cycles then high -> adbus_out=0xA5 with adbus_oe=1 in the first low cycle. rx_count 1->0 on rise. rxf_n=1 for RECOVERY=2 cycles after the rise, then stays 1 because the buffer is empty.
- Back-to-back reads: push 0x01,0x02,0x03; host FTDI interface with rd_en=1 -> its read queue receives 01,02,03 in order; rxf_n pulses high ≥RECOVERY cycles between bytes; protocol_err=0.
- Write to full: DEPTH=16, pc_pop=0, host writes 17 bytes 0x00..0x10 -> tx_count=16, txe_n=1; 17th strobe sets protocol_err and 0x10 is not stored; pc_pop x16 yields 0x00..0x0F.
- Simultaneous: rx_count=DEPTH, RD# rise (pop) coincident with pc_push 0x77 -> rx_count stays 16; 0x77 appears as the last byte read.
- Protocol error: RD#=WR#=0 same cycle -> protocol_err=1 next cycle, counts unchanged; err_clear pulse -> 0.

Source files
------------

// File: rtl/ftdi_fifo_responder.sv
// Device-side responder for the async 245 FIFO bus: answers RD#/WR# strobes,
// drives RXF#/TXE#, and buffers bytes between the host bus and a push/pop port.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | flags track buffer status, waiting for a strobe
// S_READING | RD# low, rx head presented on adbus
// S_WRITING | WR# low, byte already captured into tx buffer
// S_RECOVER | flags held high for RECOVERY cycles after a strobe
module ftdi_fifo_responder #(
    parameter int DEPTH    = 16,
    parameter int RECOVERY = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ftdi_rd_n,
    input  logic                       ftdi_wr_n,
    input  logic [7:0]                 adbus_in,
    output logic [7:0]                 adbus_out,
    output logic                       adbus_oe,
    output logic                       rxf_n,
    output logic                       txe_n,
    input  logic [7:0]                 pc_data,
    input  logic                       pc_push,
    output logic                       pc_full,
    input  logic                       pc_pop,
    output logic [7:0]                 pc_q,
    output logic                       pc_empty,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic [$clog2(DEPTH):0]     tx_count,
    input  logic                       err_clear,
    output logic                       protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READING, S_WRITING, S_RECOVER} state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rec_cnt;
    logic            r_rd_q, r_wr_q, r_rxf_n, r_txe_n, r_err;
    logic [7:0]      r_rx_mem [DEPTH];
    logic [7:0]      r_tx_mem [DEPTH];
    logic [AW-1:0]   r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
    logic [CW-1:0]   r_rx_cnt, r_tx_cnt;

    logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise, w_both_low;
    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rd_go, w_wr_go, w_err_set, w_idle;
    logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;

    assign w_rd_fall  = r_rd_q & ~ftdi_rd_n;
    assign w_rd_rise  = ~r_rd_q & ftdi_rd_n;
    assign w_wr_fall  = r_wr_q & ~ftdi_wr_n;
    assign w_wr_rise  = ~r_wr_q & ftdi_wr_n;
    assign w_both_low = ~ftdi_rd_n & ~ftdi_wr_n;
    assign w_idle     = (r_state == S_IDLE);

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));

    // A strobe is only honoured from IDLE with the other strobe released.
    assign w_rd_go   = w_idle & w_rd_fall & ~w_rx_empty & ftdi_wr_n;
    assign w_wr_go   = w_idle & w_wr_fall & ~w_tx_full & ftdi_rd_n;
    assign w_err_set = w_both_low
                     | (w_rd_fall & (~w_idle | w_rx_empty))
                     | (w_wr_fall & (~w_idle | w_tx_full));

    assign w_rx_pop  = (r_state == S_READING) & w_rd_rise;
    assign w_rx_push = pc_push & (~w_rx_full | w_rx_pop);
    assign w_tx_push = w_wr_go;
    assign w_tx_pop  = pc_pop & ~w_tx_empty;

    assign adbus_out    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
    assign adbus_oe     = ~ftdi_rd_n & (w_idle | (r_state == S_READING)) & ~w_rx_empty;
    assign pc_q         = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
    assign pc_empty     = w_tx_empty;
    assign pc_full      = w_rx_full;
    assign rx_count     = r_rx_cnt;
    assign tx_count     = r_tx_cnt;
    assign rxf_n        = r_rxf_n;
    assign txe_n        = r_txe_n;
    assign protocol_err = r_err;

    always_ff @(posedge clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= pc_data;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= adbus_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rec_cnt <= '0;
            r_rd_q    <= 1'b1;
            r_wr_q    <= 1'b1;
            r_rxf_n   <= 1'b1;
            r_txe_n   <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_rd_q <= ftdi_rd_n;
            r_wr_q <= ftdi_wr_n;
            if (w_err_set)      r_err <= 1'b1;
            else if (err_clear) r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rxf_n <= w_rx_empty;
                    r_txe_n <= w_tx_full;
                    if (w_rd_go) begin
                        r_state <= S_READING;
                        r_rxf_n <= 1'b1;
                        r_txe_n <= 1'b1;
                    end else if (w_wr_go) begin
                        r_state <= S_WRITING;
                        r_rxf_n <= 1'b1;
                        r_txe_n <= 1'b1;
                    end
                end
                S_READING: if (w_rd_rise) begin
                    r_state   <= S_RECOVER;
                    r_rec_cnt <= RW'(RECOVERY - 1);
                end
                S_WRITING: if (w_wr_rise) begin
                    r_state   <= S_RECOVER;
                    r_rec_cnt <= RW'(RECOVERY - 1);
                end
                S_RECOVER: begin
                    // Flags stay high here; IDLE refreshes them one cycle later.
                    if (r_rec_cnt == '0) r_state <= S_IDLE;
                    else                 r_rec_cnt <= r_rec_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
